min_weight_solution_sink: RTL and testbench
===========================================

Name: min_weight_solution_sink

Overview:
- AXI-stream receiver for the GF(2) solution stream produced by the solution enumerator.
- Each frame (beats up to and including tlast) carries every candidate press vector for one machine.
- Finds the minimum-Hamming-weight vector in the frame and presents weight, vector and beat count on a valid/ready result port.
- Sits between the enumerator and the per-machine answer accumulator.

Parameters:
DATA_WIDTH, 8, tdata width; must match the solution_stream interface.
COUNT_W, 16, width of the per-frame beat counter.
TOTAL_W, 32, width of the running total (used only with the optional feature).

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
solution_stream  axi_stream_if slave  DATA_WIDTH  tvalid/tready/tdata/tlast; tready driven here
vars_mask  input  DATA_WIDTH  1 = bit is a variable; 0 = padding. Sampled on the first beat of each frame.
result_valid  output  1  result available
result_ready  input  1  downstream accepts result
result_weight  output  $clog2(DATA_WIDTH+1)  minimum popcount in the frame
result_vector  output  DATA_WIDTH  masked vector achieving the minimum
result_count  output  COUNT_W  beats in the frame
total_weight  output  TOTAL_W  present only with MIN_WEIGHT_TOTAL_EN

Behaviour:
- Reset (rst_n=0 at posedge): state=COLLECT, tready=0 during reset then 1, result_valid=0, result_weight/vector/count=0, stage empty, best cleared, frame_first=1, total_weight=0.
- Datapath: two stages.
  - Stage 1 registers the accepted beat: s_data = tdata & mask, s_last, s_valid. mask = vars_mask on a first beat, else the latched mask.
  - Stage 2 computes w = popcount(s_data). It updates best when s_first, or when w < best_weight (strictly less), so ties keep the earliest beat. It increments count, saturating at all-ones.
- FSM, enum in package:
  - COLLECT: tready=1. A handshake (tvalid&tready) loads stage 1. If tlast is accepted, next state is FLUSH.
  - FLUSH: tready=0. Stage 2 consumes the final beat; next state is REPORT.
  - REPORT: tready=0, result_valid=1, outputs hold stable. On result_ready, return to COLLECT, clear best/count, set frame_first=1.
- Latency: tlast accepted at edge T; result_valid is high after edge T+2; it drops the cycle after the result handshake edge. tready is back at 1 in that same cycle.
- Throughput: one beat per cycle within a frame. Minimum 3-cycle gap between frames plus any result stall.
- Boundaries:
  - Single-beat frame (first beat has tlast): count=1, vector=that beat.
  - All-zero beat: weight 0, legal.
  - Padding bits never counted.
  - tvalid with tready=0: beat not consumed; the source holds it per AXI.
  - result_ready high before result_valid: ignored.
  - Count saturates, no wrap.
  - Reset mid-frame or mid-REPORT: partial frame discarded, all state as at reset.
- vars_mask changes mid-frame are ignored.

Optional Feature:
- Macro MIN_WEIGHT_TOTAL_EN.
- Defined: total_weight port exists. On each result handshake, total_weight += result_weight, wrapping modulo 2^TOTAL_W. Reset clears it.
- Undefined: port and adder absent; all other behaviour identical.

Decomposition:
- Package solution_sink_pkg: sink state enum (COLLECT, FLUSH, REPORT), DATA_WIDTH default constant, weight-width localparam function.
- Reuse the existing popcount module (in=s_data, n=DATA_WIDTH) as the single sub-module. No new sub-module.

Test Plan:
1. vars_mask=8'hFE; frame 8'hA0, 8'h80, 8'hFE(tlast), result_ready=1 -> weight=1, vector=8'h80, count=3; result_valid exactly 2 edges after the tlast edge.
2. Tie and padding: mask 8'hFE; frame 8'hC1, 8'h30(tlast) -> vector=8'hC0 (earliest, padding stripped), weight=2, count=2. Frame 8'h01(tlast) alone -> weight=0, vector=8'h00, count=1.
3. Backpressure: hold result_ready=0 for 5 cycles after result_valid with the next frame's tvalid=1 -> tready stays 0, result stable. Release -> second frame accepted, its result correct.
4. Reset mid-frame: send 2 beats without tlast, pulse rst_n=0 one cycle, then frame 8'hFE(tlast) -> weight=7, count=1; no residue from discarded beats.
5. Streaming rate: 10-beat frame with tvalid continuously high -> one beat accepted per cycle, count=10; min found at beat 7 is reported.
6. MIN_WEIGHT_TOTAL_EN: frames with min weights 1, 3, 2 -> total_weight=1, 4, 6 after each result handshake; 0 after reset.

Source files
------------

// File: rtl/min_weight_solution_sink_pkg.sv
// rtl/min_weight_solution_sink_pkg.sv - shared types and constants for the minimum-weight solution sink
package solution_sink_pkg;

    localparam int DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FLUSH   = 2'd1,
        REPORT  = 2'd2
    } sink_state_t;

    // Bits needed to hold a popcount of n bits (0..n inclusive).
    function automatic int weight_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/min_weight_solution_sink_if.sv
// rtl/min_weight_solution_sink_if.sv - AXI-stream interface carrying the enumerator solution stream
//
// Signals: tvalid, tready, tdata[DATA_WIDTH], tlast.
// master drives tvalid/tdata/tlast, slave drives tready.
interface axi_stream_if
    import solution_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/min_weight_solution_sink_popcount.sv
// rtl/min_weight_solution_sink_popcount.sv - combinational population count
//
// Ports: in[N] vector to count, count[$clog2(N+1)] number of set bits.
module popcount
    import solution_sink_pkg::*;
#(
    parameter int N = DATA_WIDTH_DEFAULT
) (
    input  logic [N-1:0]                in,
    output logic [weight_width(N)-1:0]  count
);
    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + $bits(count)'(in[i]);
        end
    end
endmodule

// File: rtl/min_weight_solution_sink.sv
// rtl/min_weight_solution_sink.sv - finds the minimum-Hamming-weight vector in each solution frame
//
// Optional feature macro: MIN_WEIGHT_TOTAL_EN (adds total_weight running sum).
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   solution_stream   axi_stream_if slave; one frame = beats up to and including tlast
//   vars_mask         1 = variable bit, 0 = padding; latched on the first beat of a frame
//   result_valid/ready  result handshake
//   result_weight     minimum popcount in the frame
//   result_vector     masked vector achieving the minimum (earliest on ties)
//   result_count      beats in the frame, saturating
//   total_weight      sum of reported weights (MIN_WEIGHT_TOTAL_EN only)
module min_weight_solution_sink
    import solution_sink_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int COUNT_W    = 16
`ifdef MIN_WEIGHT_TOTAL_EN
    ,
    parameter int TOTAL_W    = 32
`endif
) (
    input  logic                                clk,
    input  logic                                rst_n,
    axi_stream_if.slave                         solution_stream,
    input  logic [DATA_WIDTH-1:0]               vars_mask,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [weight_width(DATA_WIDTH)-1:0] result_weight,
    output logic [DATA_WIDTH-1:0]               result_vector,
    output logic [COUNT_W-1:0]                  result_count
`ifdef MIN_WEIGHT_TOTAL_EN
    ,
    output logic [TOTAL_W-1:0]                  total_weight
`endif
);
    localparam int WEIGHT_W = weight_width(DATA_WIDTH);

    sink_state_t state, state_next;

    logic                  accept;
    logic                  result_hs;
    logic                  frame_first;
    logic [DATA_WIDTH-1:0] mask_q;
    logic [DATA_WIDTH-1:0] mask_eff;

    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_last;
    logic                  s_valid;
    logic                  s_first;

    logic [WEIGHT_W-1:0]   w;
    logic [WEIGHT_W-1:0]   best_weight;
    logic [DATA_WIDTH-1:0] best_vector;
    logic [COUNT_W-1:0]    best_count;

    assign accept    = solution_stream.tvalid && solution_stream.tready;
    assign result_hs = result_valid && result_ready;
    // The mask is only taken from the port on a frame's first beat.
    assign mask_eff  = frame_first ? vars_mask : mask_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next             = state;
        solution_stream.tready = 1'b0;
        case (state)
            COLLECT: begin
                solution_stream.tready = rst_n;
                if (accept && solution_stream.tlast) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (s_valid && s_last) begin
                    state_next = REPORT;
                end
            end
            REPORT: begin
                if (result_hs) begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Stage 1: register the accepted, masked beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_valid     <= 1'b0;
            s_data      <= '0;
            s_last      <= 1'b0;
            s_first     <= 1'b0;
            mask_q      <= '0;
            frame_first <= 1'b1;
        end else begin
            s_valid <= accept;
            if (accept) begin
                s_data      <= solution_stream.tdata & mask_eff;
                s_last      <= solution_stream.tlast;
                s_first     <= frame_first;
                frame_first <= 1'b0;
                if (frame_first) begin
                    mask_q <= vars_mask;
                end
            end
            if (result_hs) begin
                frame_first <= 1'b1;
            end
        end
    end

    popcount #(.N(DATA_WIDTH)) u_popcount (
        .in    (s_data),
        .count (w)
    );

    // Stage 2: track the running minimum; strict less-than keeps the earliest on ties.
    always_ff @(posedge clk) begin
        if (!rst_n || result_hs) begin
            best_weight <= '0;
            best_vector <= '0;
            best_count  <= '0;
        end else if (s_valid) begin
            if (s_first || (w < best_weight)) begin
                best_weight <= w;
                best_vector <= s_data;
            end
            if (s_first) begin
                best_count <= COUNT_W'(1);
            end else if (!(&best_count)) begin
                best_count <= best_count + COUNT_W'(1);
            end
        end
    end

    // Result registers load once on REPORT entry and stay stable until accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_valid  <= 1'b0;
            result_weight <= '0;
            result_vector <= '0;
            result_count  <= '0;
        end else if ((state == REPORT) && !result_valid) begin
            result_valid  <= 1'b1;
            result_weight <= best_weight;
            result_vector <= best_vector;
            result_count  <= best_count;
        end else if (result_hs) begin
            result_valid  <= 1'b0;
        end
    end

`ifdef MIN_WEIGHT_TOTAL_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_weight <= '0;
        end else if (result_hs) begin
            total_weight <= total_weight + TOTAL_W'(result_weight);
        end
    end
`endif

endmodule

// File: tb/tb_min_weight_solution_sink.sv
// tb/tb_min_weight_solution_sink.sv - self-checking bench for min_weight_solution_sink
`timescale 1ns/1ps
module tb_min_weight_solution_sink;
    import solution_sink_pkg::*;

    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int WW   = 4;
    localparam int TW   = 32;
    localparam int CMAX = 15;

    typedef logic [7:0] byte_q_t [$];
    typedef struct {
        int         w;
        logic [7:0] v;
        int         c;
        int         lat;
        bit         stable;
        bit         hs_ok;
        int         span;
        bit         timeout;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] vars_mask;
    logic          result_valid;
    logic          result_ready;
    logic [WW-1:0] result_weight;
    logic [DW-1:0] result_vector;
    logic [CW-1:0] result_count;
`ifdef MIN_WEIGHT_TOTAL_EN
    logic [TW-1:0] total_weight;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    axi_stream_if #(.DATA_WIDTH(DW)) s_if ();

    min_weight_solution_sink #(
        .DATA_WIDTH(DW),
        .COUNT_W(CW)
`ifdef MIN_WEIGHT_TOTAL_EN
        ,
        .TOTAL_W(TW)
`endif
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .solution_stream (s_if),
        .vars_mask       (vars_mask),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_weight   (result_weight),
        .result_vector   (result_vector),
        .result_count    (result_count)
`ifdef MIN_WEIGHT_TOTAL_EN
        ,
        .total_weight    (total_weight)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: earliest beat of least popcount after masking; count saturates.
    function automatic void model(input byte_q_t beats, input logic [7:0] mask,
                                  output int w, output logic [7:0] v, output int c);
        logic [7:0] m;
        w = 1000;
        v = 8'h00;
        foreach (beats[i]) begin
            m = beats[i] & mask;
            if ($countones(m) < w) begin
                w = $countones(m);
                v = m;
            end
        end
        c = (beats.size() > CMAX) ? CMAX : beats.size();
    endfunction

    task automatic send_beat(input logic [7:0] d, input bit last, output int acc_cyc, output bit to);
        bit done = 0;
        s_if.tvalid = 1'b1;
        s_if.tdata  = d;
        s_if.tlast  = last;
        to = 1'b0;
        acc_cyc = 0;
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (s_if.tready === 1'b1) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                done = 1;
            end
        end
        if (!done) to = 1'b1;
    endtask

    task automatic drive_frame(input byte_q_t beats, input logic [7:0] mask, input int stall,
                               input bit hold_en, input logic [7:0] hold_d, output obs_t o);
        int ac, first, tl;
        bit to, got;
        o.w = 0; o.v = 8'h00; o.c = 0; o.lat = -1;
        o.stable = 1; o.hs_ok = 0; o.span = 0; o.timeout = 0;
        first = 0;
        ac = 0;
        vars_mask = mask;
        result_ready = (stall == 0);
        foreach (beats[i]) begin
            send_beat(beats[i], i == beats.size() - 1, ac, to);
            if (to) o.timeout = 1;
            if (i == 0) begin
                first = ac;
                vars_mask = 8'($urandom);
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        tl = ac;
        o.span = tl - first + 1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1) got = 1;
        end
        if (!got) o.timeout = 1;
        o.lat = cyc - tl;
        o.w = int'(result_weight);
        o.v = result_vector;
        o.c = int'(result_count);
        if (hold_en) begin
            s_if.tvalid = 1'b1;
            s_if.tdata  = hold_d;
            s_if.tlast  = 1'b0;
        end
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!(result_valid === 1'b1 && int'(result_weight) == o.w && result_vector === o.v &&
                  int'(result_count) == o.c && s_if.tready === 1'b0)) o.stable = 0;
        end
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        o.hs_ok = (result_valid === 1'b0) && (s_if.tready === 1'b1);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vars_mask = 8'h00;
        result_ready = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tdata = 8'h00;
        s_if.tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (s_if.tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready_low: got %b want 0", s_if.tready); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (s_if.tready !== 1'b1) begin n_fail++; $display("FAIL reset_tready_high: got %b want 1", s_if.tready); end
        n_cmp++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", result_valid); end
        n_cmp++; if ({result_weight, result_vector, result_count} !== '0) begin n_fail++;
            $display("FAIL reset_outputs: got w=%0d v=%h c=%0d want 0", result_weight, result_vector, result_count); end
`ifdef MIN_WEIGHT_TOTAL_EN
        n_cmp++; if (total_weight !== '0) begin n_fail++; $display("FAIL reset_total: got %0d want 0", total_weight); end
`endif
    endtask

    task automatic test_basic();
        obs_t o;
        drive_frame('{8'hA0, 8'h80, 8'hFE}, 8'hFE, 0, 0, 8'h00, o);
        n_cmp++; if (o.w != 1 || o.v !== 8'h80 || o.c != 3) begin n_fail++;
            $display("FAIL basic_result: got w=%0d v=%h c=%0d want w=1 v=80 c=3", o.w, o.v, o.c); end
        n_cmp++; if (o.lat != 2 || o.timeout) begin n_fail++; $display("FAIL basic_latency: got %0d (timeout %0b) want 2", o.lat, o.timeout); end
        n_cmp++; if (!o.hs_ok) begin n_fail++; $display("FAIL basic_handshake: got valid=%b tready=%b want 0/1", result_valid, s_if.tready); end
    endtask

    task automatic test_tie_padding();
        obs_t o;
        drive_frame('{8'hC1, 8'h30}, 8'hFE, 0, 0, 8'h00, o);
        n_cmp++; if (o.w != 2 || o.v !== 8'hC0 || o.c != 2) begin n_fail++;
            $display("FAIL tie_result: got w=%0d v=%h c=%0d want w=2 v=c0 c=2", o.w, o.v, o.c); end
        drive_frame('{8'h01}, 8'hFE, 0, 0, 8'h00, o);
        n_cmp++; if (o.w != 0 || o.v !== 8'h00 || o.c != 1) begin n_fail++;
            $display("FAIL single_zero: got w=%0d v=%h c=%0d want w=0 v=00 c=1", o.w, o.v, o.c); end
    endtask

    task automatic test_backpressure();
        obs_t o;
        int ew, ec;
        logic [7:0] ev;
        drive_frame('{8'h77, 8'h13}, 8'hFF, 5, 1, 8'h0F, o);
        n_cmp++; if (!o.stable) begin n_fail++; $display("FAIL bp_stable: got stable=0 want 1"); end
        n_cmp++; if (o.w != 3 || o.v !== 8'h13 || o.c != 2) begin n_fail++;
            $display("FAIL bp_first: got w=%0d v=%h c=%0d want w=3 v=13 c=2", o.w, o.v, o.c); end
        drive_frame('{8'h0F, 8'h3C, 8'h81}, 8'hFF, 0, 0, 8'h00, o);
        model('{8'h0F, 8'h3C, 8'h81}, 8'hFF, ew, ev, ec);
        n_cmp++; if (o.w != ew || o.v !== ev || o.c != ec) begin n_fail++;
            $display("FAIL bp_second: got w=%0d v=%h c=%0d want w=%0d v=%h c=%0d", o.w, o.v, o.c, ew, ev, ec); end
    endtask

    task automatic test_reset_mid_frame();
        obs_t o;
        int ac;
        bit to;
        vars_mask = 8'h0F;
        send_beat(8'h3C, 0, ac, to);
        send_beat(8'h81, 0, ac, to);
        s_if.tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (result_valid !== 1'b0 || result_count !== '0 || result_weight !== '0) begin n_fail++;
            $display("FAIL midreset_clear: got valid=%b w=%0d c=%0d want 0", result_valid, result_weight, result_count); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_frame('{8'hFE}, 8'hFE, 0, 0, 8'h00, o);
        n_cmp++; if (o.w != 7 || o.v !== 8'hFE || o.c != 1 || o.timeout) begin n_fail++;
            $display("FAIL midreset_frame: got w=%0d v=%h c=%0d want w=7 v=fe c=1", o.w, o.v, o.c); end
    endtask

    task automatic test_streaming();
        obs_t o;
        byte_q_t b;
        int ew, ec;
        logic [7:0] ev;
        for (int i = 0; i < 10; i++) b.push_back((i == 6) ? 8'h01 : (8'($urandom) | 8'h03));
        drive_frame(b, 8'hFF, 0, 0, 8'h00, o);
        n_cmp++; if (o.w != 1 || o.v !== 8'h01 || o.c != 10) begin n_fail++;
            $display("FAIL stream_result: got w=%0d v=%h c=%0d want w=1 v=01 c=10", o.w, o.v, o.c); end
        n_cmp++; if (o.span != 10) begin n_fail++; $display("FAIL stream_rate: got %0d cycles want 10", o.span); end
        b.delete();
        for (int i = 0; i < 20; i++) b.push_back(8'($urandom));
        model(b, 8'hFF, ew, ev, ec);
        drive_frame(b, 8'hFF, 0, 0, 8'h00, o);
        n_cmp++; if (o.w != ew || o.v !== ev || o.c != ec) begin n_fail++;
            $display("FAIL saturate: got w=%0d v=%h c=%0d want w=%0d v=%h c=%0d", o.w, o.v, o.c, ew, ev, ec); end
    endtask

    task automatic test_random();
        obs_t o;
        byte_q_t b;
        int ew, ec, len, st;
        logic [7:0] ev, mask;
        for (int f = 0; f < 25; f++) begin
            b.delete();
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) b.push_back(8'($urandom));
            mask = 8'($urandom);
            st = $urandom_range(0, 3);
            model(b, mask, ew, ev, ec);
            drive_frame(b, mask, st, 0, 8'h00, o);
            n_cmp++; if (o.w != ew || o.v !== ev || o.c != ec) begin n_fail++;
                $display("FAIL random_%0d: got w=%0d v=%h c=%0d want w=%0d v=%h c=%0d", f, o.w, o.v, o.c, ew, ev, ec); end
            n_cmp++; if (o.lat != 2 || !o.stable || !o.hs_ok || o.timeout) begin n_fail++;
                $display("FAIL random_timing_%0d: got lat=%0d stable=%0b hs=%0b to=%0b want 2/1/1/0", f, o.lat, o.stable, o.hs_ok, o.timeout); end
        end
    endtask

`ifdef MIN_WEIGHT_TOTAL_EN
    task automatic test_total();
        obs_t o;
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (total_weight !== '0) begin n_fail++; $display("FAIL total_reset: got %0d want 0", total_weight); end
        @(negedge clk);
        rst_n = 1'b1;
        drive_frame('{8'h03, 8'h01}, 8'hFF, 0, 0, 8'h00, o);
        n_cmp++; if (total_weight !== TW'(1)) begin n_fail++; $display("FAIL total_1: got %0d want 1", total_weight); end
        drive_frame('{8'h07}, 8'hFF, 2, 0, 8'h00, o);
        n_cmp++; if (total_weight !== TW'(4)) begin n_fail++; $display("FAIL total_2: got %0d want 4", total_weight); end
        drive_frame('{8'h0F, 8'h05}, 8'hFF, 0, 0, 8'h00, o);
        n_cmp++; if (total_weight !== TW'(6)) begin n_fail++; $display("FAIL total_3: got %0d want 6", total_weight); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_tie_padding();
        test_backpressure();
        test_reset_mid_frame();
        test_streaming();
        test_random();
`ifdef MIN_WEIGHT_TOTAL_EN
        test_total();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
